// File: rtl/rtl_kernel_wizard_0_stream_arbiter_if.sv
// ---------------------------------------------------------------------------
// rtl_kernel_wizard_0_stream_arbiter_if
//
// Bundle of AXI4-Stream handshake and payload signals used by the
// rtl_kernel_wizard_0_stream_arbiter. One instance can carry several parallel
// lanes (the arbiter's slave side) or a single lane (its master side).
//
// Parameters:
//   NUM_LANES   number of parallel streams carried by this bundle
//   DATA_WIDTH  tdata width per lane in bits (multiple of 8)
//
// Signals (per lane, packed lane-major):
//   tvalid  [NUM_LANES]               beat valid
//   tready  [NUM_LANES]               beat accepted
//   tdata   [NUM_LANES*DATA_WIDTH]    lane p at [p*DATA_WIDTH +: DATA_WIDTH]
//   tkeep   [NUM_LANES*DATA_WIDTH/8]  byte qualifiers
//   tlast   [NUM_LANES]               final beat of a packet
//
// Modports:
//   master  drives tvalid/tdata/tkeep/tlast, receives tready
//   slave   receives tvalid/tdata/tkeep/tlast, drives tready
// ---------------------------------------------------------------------------
interface rtl_kernel_wizard_0_stream_arbiter_if #(
   parameter int unsigned NUM_LANES  = 1,
   parameter int unsigned DATA_WIDTH = 128
);

   logic [NUM_LANES-1:0]              tvalid;
   logic [NUM_LANES-1:0]              tready;
   logic [NUM_LANES*DATA_WIDTH-1:0]   tdata;
   logic [NUM_LANES*DATA_WIDTH/8-1:0] tkeep;
   logic [NUM_LANES-1:0]              tlast;

   modport master (
      output tvalid,
      output tdata,
      output tkeep,
      output tlast,
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tdata,
      input  tkeep,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/rtl_kernel_wizard_0_stream_arbiter.sv
// ---------------------------------------------------------------------------
// rtl_kernel_wizard_0_stream_arbiter
//
// Packet-locked round-robin arbiter: shares one AXI4-Stream master among
// C_NUM_PORTS slave streams. A grant is held for a whole packet and released
// on the tlast handshake; one IDLE bubble cycle separates packets. Every
// output beat is tagged with the source port index on m_axis_tid.
//
// Optional feature macro: RTL_KERNEL_WIZARD_0_STREAM_ARB_STATS_EN
//   defined   -> per-port saturating 32-bit completed-packet counters
//   undefined -> pkt_count tied to zero, no counter logic
//
// Ports:
//   aclk         clock
//   areset       synchronous active-high reset
//   port_enable  per-port enable mask, only looked at during arbitration
//   s_axis       slave bundle, C_NUM_PORTS lanes (requesting streams)
//   m_axis       master bundle, 1 lane (shared output stream)
//   m_axis_tid   index of the port owning the current beat
//   grant_idx    current or most recent grant
//   busy         high while a packet is locked
//   pkt_done     one-cycle pulse on the final handshake of a packet
//   pkt_count    per-port completed-packet counters, 32 bits each
// ---------------------------------------------------------------------------
module rtl_kernel_wizard_0_stream_arbiter #(
   parameter int unsigned  C_NUM_PORTS   = 4,
   parameter int unsigned  C_TDATA_WIDTH = 128,
   localparam int unsigned LP_ID_WIDTH   = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [C_NUM_PORTS-1:0]        port_enable,
   rtl_kernel_wizard_0_stream_arbiter_if.slave  s_axis,
   rtl_kernel_wizard_0_stream_arbiter_if.master m_axis,
   output logic [LP_ID_WIDTH-1:0]        m_axis_tid,
   output logic [LP_ID_WIDTH-1:0]        grant_idx,
   output logic                          busy,
   output logic                          pkt_done,
   output logic [C_NUM_PORTS*32-1:0]     pkt_count
);

   localparam int unsigned KeepWidth = C_TDATA_WIDTH / 8;

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e                   state_q, state_d;
   logic [LP_ID_WIDTH-1:0]   grant_q, grant_d;
   logic [LP_ID_WIDTH-1:0]   last_q, last_d;

   logic [C_NUM_PORTS-1:0]   req;
   logic                     rr_found;
   logic [LP_ID_WIDTH-1:0]   rr_sel;

   logic                     sel_valid;
   logic                     sel_last;
   logic [C_TDATA_WIDTH-1:0] sel_data;
   logic [KeepWidth-1:0]     sel_keep;

   // Round-robin search starting one past the previous winner, with wrap.
   always_comb begin
      int unsigned cand;
      cand     = 0;
      req      = s_axis.tvalid & port_enable;
      rr_found = 1'b0;
      rr_sel   = '0;
      for (int unsigned off = 1; off <= C_NUM_PORTS; off++) begin
         cand = 32'(last_q) + off;
         if (cand >= C_NUM_PORTS) begin
            cand = cand - C_NUM_PORTS;
         end
         if (!rr_found && req[cand]) begin
            rr_found = 1'b1;
            rr_sel   = LP_ID_WIDTH'(cand);
         end
      end
   end

   // Granted-lane mux; a decoded loop keeps out-of-range indices harmless.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      for (int unsigned p = 0; p < C_NUM_PORTS; p++) begin
         if (grant_q == LP_ID_WIDTH'(p)) begin
            sel_valid = s_axis.tvalid[p];
            sel_last  = s_axis.tlast[p];
            sel_data  = s_axis.tdata[p*C_TDATA_WIDTH +: C_TDATA_WIDTH];
            sel_keep  = s_axis.tkeep[p*KeepWidth +: KeepWidth];
         end
      end
   end

   // Next state and stream outputs.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_d        = last_q;
      pkt_done      = 1'b0;
      s_axis.tready = '0;
      m_axis.tvalid = '0;
      m_axis.tlast  = '0;
      m_axis.tdata  = sel_data;
      m_axis.tkeep  = sel_keep;

      unique case (state_q)
         StIdle: begin
            if (rr_found) begin
               grant_d = rr_sel;
               state_d = StLocked;
            end
         end
         StLocked: begin
            m_axis.tvalid[0] = sel_valid;
            m_axis.tlast[0]  = sel_last;
            for (int unsigned p = 0; p < C_NUM_PORTS; p++) begin
               if (grant_q == LP_ID_WIDTH'(p)) begin
                  s_axis.tready[p] = m_axis.tready[0];
               end
            end
            if (sel_valid && m_axis.tready[0] && sel_last) begin
               pkt_done = 1'b1;
               last_d   = grant_q;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= StIdle;
         grant_q <= '0;
         // Previous winner = last port, so the first search starts at port 0.
         last_q  <= LP_ID_WIDTH'(C_NUM_PORTS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   assign grant_idx  = grant_q;
   assign m_axis_tid = grant_q;
   assign busy       = (state_q == StLocked);

`ifdef RTL_KERNEL_WIZARD_0_STREAM_ARB_STATS_EN
   logic [31:0] cnt_q [C_NUM_PORTS];

   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int unsigned p = 0; p < C_NUM_PORTS; p++) begin
            cnt_q[p] <= '0;
         end
      end else if (pkt_done) begin
         for (int unsigned p = 0; p < C_NUM_PORTS; p++) begin
            if (grant_q == LP_ID_WIDTH'(p) && cnt_q[p] != 32'hFFFF_FFFF) begin
               cnt_q[p] <= cnt_q[p] + 32'd1;
            end
         end
      end
   end

   always_comb begin
      pkt_count = '0;
      for (int unsigned p = 0; p < C_NUM_PORTS; p++) begin
         pkt_count[p*32 +: 32] = cnt_q[p];
      end
   end
`else
   assign pkt_count = '0;
`endif

endmodule
